// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter with a one-entry input buffer, an internal bit divider and optional parity.
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic [1:0]           field_sel,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int SW = $clog2(STOP_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SW-1:0]        stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, buf_q, buf_d, word;
  logic                 par_q, par_d, buf_full_q, buf_full_d, tx_out_q, tx_out_d;
  logic                 bit_end, last_stop, xfer, avail, load;
  assign bit_end   = state_q != IDLE && div_q == DW'(CLKS_PER_BIT - 1);
  assign last_stop = state_q == STOP && bit_end && stop_q == SW'(STOP_BITS - 1);
  assign xfer      = tx_valid && !buf_full_q;
  assign avail     = buf_full_q || xfer;
  assign load      = state_q == IDLE || last_stop;
  assign word      = buf_full_q ? buf_q : tx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      stop_q     <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      par_q      <= 1'b0;
      buf_full_q <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      par_q      <= par_d;
      buf_full_q <= buf_full_d;
      tx_out_q   <= tx_out_d;
    end
  always_comb begin
    state_d    = state_q;
    div_d      = (state_q == IDLE || bit_end) ? '0 : div_q + DW'(1);
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    par_d      = par_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    // at a load point a word arriving with the buffer empty bypasses it
    if (load && avail) begin
      shift_d    = word;
      par_d      = (PARITY_MODE == 2) ? ~^word : ^word;
      buf_full_d = 1'b0;
    end else if (xfer) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
    case (state_q)
      IDLE:   if (avail) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BW'(1);
        if (bit_q == BW'(DATA_BITS - 1)) begin
          bit_d = '0;
          if (PARITY_MODE != 0) state_d = PARITY;
          else state_d = STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) begin
        stop_d = stop_q + SW'(1);
        if (last_stop) begin
          stop_d = '0;
          if (avail) state_d = START;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_out_d   = state_d == START  ? 1'b0 :
                 state_d == DATA   ? shift_d[0] :
                 state_d == PARITY ? par_d : 1'b1;
    tx_out     = tx_out_q;
    tx_ready   = !buf_full_q;
    busy       = state_q != IDLE;
    frame_done = last_stop;
    field_sel  = state_q == START  ? 2'b00 :
                 state_q == DATA   ? 2'b01 :
                 state_q == PARITY ? 2'b10 : 2'b11;
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: four framer configurations checked every cycle against a frame-level model plus directed literal checks.
module tb_uart_tx_framer;
  function automatic int db_of(input int g);
    return g == 0 ? 8 : g == 3 ? 5 : 7;
  endfunction
  function automatic int pm_of(input int g);
    return g == 1 ? 1 : g == 2 ? 2 : 0;
  endfunction
  function automatic int sb_of(input int g);
    return g == 3 ? 2 : 1;
  endfunction
  function automatic int cpb_of(input int g);
    return g == 0 ? 16 : 4;
  endfunction
  function automatic int flen(input int g);
    return (1 + db_of(g) + (pm_of(g) != 0 ? 1 : 0) + sb_of(g)) * cpb_of(g);
  endfunction
  logic       clk;
  logic       rst_v[4];
  logic       valid_v[4];
  logic [8:0] data_v[4];
  logic       tx_ready_v[4], tx_out_v[4], busy_v[4], done_v[4];
  logic [1:0] field_v[4];
  int         checks, errors;
  int         pos[4];
  logic       bv[4];
  logic [8:0] bd[4];
  logic [15:0] fr[4];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int DB = db_of(g);
    uart_tx_framer #(
      .DATA_BITS(DB), .PARITY_MODE(pm_of(g)), .STOP_BITS(sb_of(g)), .CLKS_PER_BIT(cpb_of(g))
    ) dut (
      .clk(clk), .rst_n(rst_v[g]), .tx_data(data_v[g][DB-1:0]), .tx_valid(valid_v[g]),
      .tx_ready(tx_ready_v[g]), .tx_out(tx_out_v[g]), .field_sel(field_v[g]),
      .busy(busy_v[g]), .frame_done(done_v[g])
    );
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] build(input int g, input logic [8:0] w);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < db_of(g); i++) begin
      f[1 + i] = w[i];
      ones += int'(w[i]);
    end
    if (pm_of(g) != 0) f[db_of(g) + 1] = ((ones % 2) == 1) ^ (pm_of(g) == 2);
    return f;
  endfunction
  task automatic model_step();
    for (int g = 0; g < 4; g++) begin
      if (!rst_v[g]) begin
        pos[g] = -1;
        bv[g] = 1'b0;
      end else begin
        if (valid_v[g] && !bv[g]) begin
          bv[g] = 1'b1;
          bd[g] = data_v[g];
        end
        if (pos[g] < 0 || pos[g] == flen(g) - 1) begin
          if (bv[g]) begin
            fr[g] = build(g, bd[g]);
            bv[g] = 1'b0;
            pos[g] = 0;
          end else pos[g] = -1;
        end else pos[g]++;
      end
    end
  endtask
  task automatic compare_all();
    int eo, er, eb, ef, ed, b;
    for (int g = 0; g < 4; g++) begin
      eo = 1; er = 1; eb = 0; ef = 3; ed = 0;
      if (rst_v[g] && pos[g] >= 0) begin
        b = pos[g] / cpb_of(g);
        eo = int'(fr[g][b]);
        eb = 1;
        ef = b == 0 ? 0 : b <= db_of(g) ? 1 : (pm_of(g) != 0 && b == db_of(g) + 1) ? 2 : 3;
        ed = pos[g] == flen(g) - 1 ? 1 : 0;
      end
      if (rst_v[g]) er = bv[g] ? 0 : 1;
      chk($sformatf("u%0d.tx_out", g), int'(tx_out_v[g]), eo);
      chk($sformatf("u%0d.tx_ready", g), int'(tx_ready_v[g]), er);
      chk($sformatf("u%0d.busy", g), int'(busy_v[g]), eb);
      chk($sformatf("u%0d.field_sel", g), int'(field_v[g]), ef);
      chk($sformatf("u%0d.frame_done", g), int'(done_v[g]), ed);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    logic [9:0] a5;
    int done_at, drops, highs;
    checks = 0;
    errors = 0;
    a5 = 10'b1101001010;
    for (int g = 0; g < 4; g++) begin
      rst_v[g] = 1'b0; valid_v[g] = 1'b0; data_v[g] = '0;
      pos[g] = -1; bv[g] = 1'b0; bd[g] = '0; fr[g] = '1;
    end
    run(3);
    for (int g = 0; g < 4; g++) rst_v[g] = 1'b1;
    run(2);
    chk("reset_tx_out", int'(tx_out_v[0]), 1);
    chk("reset_ready", int'(tx_ready_v[0]), 1);
    chk("reset_busy", int'(busy_v[0]), 0);
    chk("reset_field", int'(field_v[0]), 3);
    chk("reset_done", int'(done_v[0]), 0);
    // 0xA5 on the default configuration
    data_v[0] = 9'h0A5; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 161; k++) begin
      if (k == 1) chk("a5_latency", int'(tx_out_v[0]), 0);
      if (k % 16 == 8) chk($sformatf("a5_bit%0d", k / 16), int'(tx_out_v[0]), int'(a5[k / 16]));
      if (done_v[0]) done_at = k;
      if (k == 161) chk("a5_idle_busy", int'(busy_v[0]), 0);
      tick();
    end
    chk("a5_done_cycle", done_at, 160);
    // 0x55 with even (u1) and odd (u2) parity
    data_v[1] = 9'h055; data_v[2] = 9'h055; valid_v[1] = 1'b1; valid_v[2] = 1'b1;
    tick();
    valid_v[1] = 1'b0; valid_v[2] = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      if (k == 2) chk("p_field_start", int'(field_v[1]), 0);
      if (k == 6) chk("p_field_data", int'(field_v[1]), 1);
      if (k == 34) begin
        chk("p_field_parity", int'(field_v[1]), 2);
        chk("p_even_bit", int'(tx_out_v[1]), 0);
        chk("p_odd_bit", int'(tx_out_v[2]), 1);
      end
      if (k == 38) chk("p_field_stop", int'(field_v[2]), 3);
      if (k == 40) chk("p_done", int'(done_v[1]), 1);
      tick();
    end
    // back-to-back through the buffer
    data_v[0] = 9'h001; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    run(19);
    data_v[0] = 9'h0FF; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    chk("b2b_ready_low", int'(tx_ready_v[0]), 0);
    drops = 0;
    for (int k = 21; k < 161; k++) begin
      if (!busy_v[0]) drops++;
      tick();
    end
    chk("b2b_busy_drops", drops, 0);
    chk("b2b_start", int'(tx_out_v[0]), 0);
    chk("b2b_field", int'(field_v[0]), 0);
    chk("b2b_busy", int'(busy_v[0]), 1);
    chk("b2b_ready_back", int'(tx_ready_v[0]), 1);
    run(160);
    // bypass during the final stop cycle
    data_v[0] = 9'h03C; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    run(159);
    chk("byp_last_stop", int'(done_v[0]), 1);
    data_v[0] = 9'h0C3; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    chk("byp_start", int'(tx_out_v[0]), 0);
    chk("byp_busy", int'(busy_v[0]), 1);
    chk("byp_ready", int'(tx_ready_v[0]), 1);
    run(160);
    // two stop bits, 4 clocks per bit, 5 data bits
    data_v[3] = 9'h01A; valid_v[3] = 1'b1;
    tick();
    valid_v[3] = 1'b0;
    done_at = 0; highs = 0;
    for (int k = 1; k <= 33; k++) begin
      if (k >= 25 && k <= 32 && tx_out_v[3]) highs++;
      if (done_v[3]) done_at = k;
      if (k == 33) chk("s2_idle_busy", int'(busy_v[3]), 0);
      tick();
    end
    chk("s2_stop_high", highs, 8);
    chk("s2_done_cycle", done_at, 32);
    // reset mid-DATA with the buffer full
    data_v[0] = 9'h000; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    run(4);
    data_v[0] = 9'h099; valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    chk("rst_buf_full", int'(tx_ready_v[0]), 0);
    run(34);
    chk("rst_pre_line", int'(tx_out_v[0]), 0);
    rst_v[0] = 1'b0;
    #1;
    chk("rst_line", int'(tx_out_v[0]), 1);
    chk("rst_ready", int'(tx_ready_v[0]), 1);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_field", int'(field_v[0]), 3);
    run(2);
    rst_v[0] = 1'b1;
    highs = 0;
    for (int k = 0; k < 400; k++) begin
      if (busy_v[0] || !tx_out_v[0]) highs++;
      tick();
    end
    chk("rst_no_resend", highs, 0);
    // random traffic on all configurations, rising offered load
    for (int c = 0; c < 4000; c++) begin
      for (int g = 0; g < 4; g++) begin
        valid_v[g] = $urandom_range(0, 7) < (c / 1000 + 1);
        data_v[g] = 9'($urandom);
      end
      tick();
    end
    for (int g = 0; g < 4; g++) valid_v[g] = 1'b0;
    run(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer: accepts parallel words over a valid/ready handshake, holds one word in a single-entry buffer, and serialises it LSB-first as start, data, optional parity and one or two stop bits. Bit timing comes from an internal divider. It replaces the fixed combinational start/data/parity/stop line select in the UART transmit path. It drives the serial line directly and reports the current frame field on `field_sel`, using the same 2-bit encoding as the line select.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, legal >= 2.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: buffer can accept a word; a transfer occurs on an edge where `tx_valid && tx_ready`.
- `tx_out` out 1: serial line, idle high; registered.
- `field_sel` out 2: current field: 00 start, 01 data, 10 parity, 11 stop/idle.
- `busy` out 1: a frame is on the line.
- `frame_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when a word is available (buffer or bypass).
  - START -> DATA after 1 bit period.
  - DATA -> PARITY after DATA_BITS bit periods, or -> STOP if PARITY_MODE = 0.
  - PARITY -> STOP after 1 bit period.
  - STOP -> START if a word is available at the last stop cycle; otherwise -> IDLE.
- Line levels by state:
  - `tx_out` = 0 in START.
  - `tx_out` = shift_reg[0] in DATA; shift right once per bit period.
  - `tx_out` = parity in PARITY.
  - `tx_out` = 1 in STOP and IDLE.
- Parity is latched when the word loads into the shifter.
  - Even: XOR of data bits, so total ones including parity is even.
  - Odd: inverted XOR.
- Divider: counter 0..CLKS_PER_BIT-1, restarted at every bit boundary; width $clog2(CLKS_PER_BIT). Bit index counter width $clog2(DATA_BITS+1). Stop bit counter counts up to STOP_BITS.
- Buffer: one entry. `tx_ready` = buffer empty.
- Shifter load points: in IDLE, or at the last cycle of the final stop bit. At a load point the shifter takes the buffered word if the buffer is full. Otherwise, if a transfer happens on that same edge, the incoming word bypasses the buffer straight into the shifter and the buffer stays empty.
- Transfer while the shifter is mid-frame: the word goes into the buffer and `tx_ready` drops next cycle.
- `tx_data` is sampled only at the transfer edge; later changes have no effect.
- `busy` = 1 in START/DATA/PARITY/STOP.
- `field_sel` = 00/01/10/11 for START/DATA/PARITY/STOP; 11 in IDLE.

## Timing
- Reset (async assert, applies immediately, including mid-frame):
  - Outputs: `tx_out` = 1, `tx_ready` = 1, `busy` = 0, `frame_done` = 0, `field_sel` = 11.
  - Internal: state IDLE, buffer emptied, counters 0.
  - A partial frame is abandoned and the line returns high at once.
- Deassertion takes effect on the first rising edge after `rst_n` goes high.
- Latency: transfer at edge N in IDLE -> `tx_out` low from the cycle after edge N.
- Frame length: F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles. Every bit holds exactly CLKS_PER_BIT cycles.
- Back-to-back frames: with the buffer full at the end of a frame, the next start bit follows the final stop cycle directly. There are no idle cycles, and `busy` stays 1 across the boundary.
- `frame_done` asserts in cycle F of each frame, including frames followed immediately by another.
- `tx_ready` falls the cycle after a buffered (non-bypass) transfer. It rises the cycle after the buffer drains into the shifter.
- `tx_valid` held with `tx_ready` = 0: no transfer and no state change from that input.
- Illegal parameter values are out of scope; the design need not detect them.

## Test plan
- Defaults, send 0xA5 from idle: line is 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 16 cycles, frame is 160 cycles, `frame_done` pulses in cycle 160.
- PARITY_MODE = 1, DATA_BITS = 7, send 0x55 (four ones): parity bit = 0. With PARITY_MODE = 2: parity bit = 1. `field_sel` steps through 00, 01, 10, 11.
- Send 0x01, then 0xFF during the first frame: `tx_ready` goes low after the second transfer. The second start bit begins in the cycle after the first frame's last stop cycle, with `busy` never deasserting.
- Transfer during the final stop cycle with the buffer empty: bypass loads the word, the next start follows with zero gap, and `tx_ready` stays 1.
- STOP_BITS = 2, CLKS_PER_BIT = 4, DATA_BITS = 5: frame is 32 cycles, with the line high for the last 8.
- `rst_n` pulsed low mid-DATA with the buffer full: `tx_out` goes to 1 immediately and `tx_ready` = 1. After release, the line stays idle and the buffered word is never sent.
